el2_lsu_ecc_scrub: RTL
======================

Name: el2_lsu_ecc_scrub

Overview:
- Downstream consumer of the LSU ECC correction stage.
- Captures single-bit-error corrections reported at R-stage (address plus corrected lo/hi bank data) into a small queue.
- Re-encodes each corrected word and issues DCCM write-back requests to the DCCM port arbiter under a valid/ready handshake.
- Keeps a saturating correction counter with a threshold interrupt for the TLU.

Parameters:
DCCM_BITS, 16, DCCM byte-address width
DCCM_DATA_WIDTH, 32, bank data width
DCCM_ECC_WIDTH, 7, ECC bits per bank word
QDEPTH, 2, correction queue entries (power of 2, ≥2)
CNT_WIDTH, 16, correction counter width

Ports:
clk  in  1  core clock
rst_l  in  1  reset, asynchronous, active-low
dec_tlu_core_ecc_disable  in  1  blocks new captures; queued entries still drain
corr_valid_r  in  1  committed load/store had a single ECC error this cycle
corr_lo_r  in  1  lo bank corrected
corr_hi_r  in  1  hi bank corrected
corr_addr_lo_r  in  DCCM_BITS  lo bank address
corr_addr_hi_r  in  DCCM_BITS  hi bank address
sec_data_lo_r  in  DCCM_DATA_WIDTH  corrected lo data
sec_data_hi_r  in  DCCM_DATA_WIDTH  corrected hi data
scrub_wr_ready  in  1  arbiter grants DCCM write port this cycle
scrub_wr_valid  out  1  write-back request
scrub_wr_addr  out  DCCM_BITS  write address
scrub_wr_data  out  DCCM_DATA_WIDTH  write data
scrub_wr_ecc  out  DCCM_ECC_WIDTH  ECC for scrub_wr_data (rvecc_encode)
scrub_busy  out  1  queue non-empty or write pending
scrub_overflow  out  1  sticky: capture dropped while full
corr_thresh  in  CNT_WIDTH  interrupt threshold; 0 disables
corr_count_clr  in  1  clears counter and scrub_overflow
corr_count  out  CNT_WIDTH  saturating correction count
corr_thresh_intr  out  1  one-cycle pulse on reaching threshold

Behaviour:
- Reset: all outputs 0, queue empty, FSM IDLE. The reset is asynchronous and may occur mid-write; any in-flight entry is discarded.
- Capture condition: corr_valid_r & (corr_lo_r | corr_hi_r) & ~dec_tlu_core_ecc_disable.
- On capture, the entry {lo flag, hi flag, both addresses, both data words} is pushed in the same cycle.
- Push is accepted if the queue is not full, or if a pop occurs in the same cycle.
- If the queue is full with no pop, the capture is dropped, scrub_overflow sets at the next edge, and corr_count still increments.
- Read/write pointers are log2(QDEPTH)+1 bits; full = MSBs differ and lower bits equal. Pointer wrap is natural.
- FSM states: IDLE, WR_LO, WR_HI.
  - IDLE with queue non-empty: go to WR_LO if the head lo flag is set, else WR_HI.
  - WR_LO: scrub_wr_valid=1, addr/data = head lo fields. On ready: go to WR_HI if the head hi flag is set; otherwise pop and return to IDLE.
  - WR_HI: drive head hi fields. On ready: pop and return to IDLE.
- Valid/address/data are held stable until ready. Valid is never withdrawn before ready.
- Minimum latency: capture at edge N gives scrub_wr_valid high in cycle N+2 (queue write at N, IDLE decode at N+1). The IDLE bubble after each pop is required.
- ecc_disable asserted mid-drain has no effect on the drain.
- scrub_wr_ecc is combinational from scrub_wr_data, with the encoder instantiated inside this block.
- Counter:
  - Increments by 1 per capture event, not per bank, and saturates at all-ones.
  - corr_count_clr wins over a same-cycle increment: result 0.
  - corr_thresh_intr pulses for one cycle at the edge where the counter value becomes exactly corr_thresh (corr_thresh≠0).
  - No pulse while the counter holds at saturation.
- scrub_busy = queue non-empty | (state≠IDLE).

Test Plan:
- Lo-only correction at addr 0x0100, data 0xDEADBEEF, ready tied 1 → one write, addr 0x0100, data 0xDEADBEEF, ECC = encoder(0xDEADBEEF), valid seen 2 cycles after capture; corr_count=1.
- Dual-bank correction, lo addr 0x01FC, hi addr 0x0200, ready held 0 for 5 cycles → valid held with lo fields stable; then lo write, hi write on consecutive ready cycles; busy drops after.
- QDEPTH=2, ready=0, three captures on consecutive cycles → third dropped, scrub_overflow=1, corr_count=3, exactly two entries drained after ready=1.
- corr_thresh=3, four captures → corr_thresh_intr single pulse coinciding with count 3; corr_count_clr with capture in same cycle → count 0.
- CNT_WIDTH=4, 17 captures → count saturates at 15, no further intr pulse.
- ecc_disable=1 during capture → no entry queued, count unchanged; rst_l low mid-WR_HI → valid 0 immediately, queue empty after release.

Source files
------------

// File: rtl/el2_lsu_ecc_scrub_if.sv
// DCCM scrub write-back channel between the ECC scrubber and the DCCM port arbiter.
// The master holds valid/addr/data/ecc stable until the arbiter returns ready.
interface el2_lsu_ecc_scrub_if #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7
);
  logic                       scrub_wr_valid;
  logic                       scrub_wr_ready;
  logic [DCCM_BITS-1:0]       scrub_wr_addr;
  logic [DCCM_DATA_WIDTH-1:0] scrub_wr_data;
  logic [DCCM_ECC_WIDTH-1:0]  scrub_wr_ecc;

  modport master (
    output scrub_wr_valid, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
    input  scrub_wr_ready
  );

  modport slave (
    input  scrub_wr_valid, scrub_wr_addr, scrub_wr_data, scrub_wr_ecc,
    output scrub_wr_ready
  );
endinterface

// File: rtl/el2_lsu_ecc_scrub.sv
// Queues R-stage single-bit ECC corrections and writes the corrected words back to the DCCM,
// with a saturating correction counter and a threshold interrupt.
module el2_lsu_ecc_scrub #(
  parameter int DCCM_BITS       = 16,
  parameter int DCCM_DATA_WIDTH = 32,
  parameter int DCCM_ECC_WIDTH  = 7,
  parameter int QDEPTH          = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       dec_tlu_core_ecc_disable,
  input  logic                       corr_valid_r,
  input  logic                       corr_lo_r,
  input  logic                       corr_hi_r,
  input  logic [DCCM_BITS-1:0]       corr_addr_lo_r,
  input  logic [DCCM_BITS-1:0]       corr_addr_hi_r,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_lo_r,
  input  logic [DCCM_DATA_WIDTH-1:0] sec_data_hi_r,
  el2_lsu_ecc_scrub_if.master        wr,
  output logic                       scrub_busy,
  output logic                       scrub_overflow,
  input  logic [CNT_WIDTH-1:0]       corr_thresh,
  input  logic                       corr_count_clr,
  output logic [CNT_WIDTH-1:0]       corr_count,
  output logic                       corr_thresh_intr
);

  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WR_LO = 2'd1, WR_HI = 2'd2} state_t;

  // Hamming SEC over positions 1..N (check bits at powers of two) plus overall parity in the MSB.
  function automatic logic [DCCM_ECC_WIDTH-1:0] ecc_encode(input logic [DCCM_DATA_WIDTH-1:0] d);
    logic [DCCM_ECC_WIDTH-1:0] e;
    int unsigned pos;
    e   = '0;
    pos = 2;
    for (int k = 0; k < DCCM_DATA_WIDTH; k++) begin
      pos = pos + 1;
      if ((pos & (pos - 1)) == 0) pos = pos + 1;
      for (int i = 0; i < DCCM_ECC_WIDTH - 1; i++)
        if (pos[i]) e[i] = e[i] ^ d[k];
    end
    e[DCCM_ECC_WIDTH-1] = ^{d, e[DCCM_ECC_WIDTH-2:0]};
    return e;
  endfunction

  logic                       q_lo      [QDEPTH];
  logic                       q_hi      [QDEPTH];
  logic [DCCM_BITS-1:0]       q_addr_lo [QDEPTH];
  logic [DCCM_BITS-1:0]       q_addr_hi [QDEPTH];
  logic [DCCM_DATA_WIDTH-1:0] q_data_lo [QDEPTH];
  logic [DCCM_DATA_WIDTH-1:0] q_data_hi [QDEPTH];

  logic [PW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 q_empty, q_full;
  logic                 capture, push, pop, drop;
  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next, cnt_plus;
  logic                 intr_reg, intr_next;
  logic                 ovf_reg;

  assign wr_idx  = wr_ptr_reg[AW-1:0];
  assign rd_idx  = rd_ptr_reg[AW-1:0];
  assign q_empty = (wr_ptr_reg == rd_ptr_reg);
  assign q_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);

  assign capture = corr_valid_r & (corr_lo_r | corr_hi_r) & ~dec_tlu_core_ecc_disable;
  assign pop     = wr.scrub_wr_ready &
                   (((state_reg == WR_LO) & ~q_hi[rd_idx]) | (state_reg == WR_HI));
  assign push    = capture & (~q_full | pop);
  assign drop    = capture & q_full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      q_lo[wr_idx]      <= corr_lo_r;
      q_hi[wr_idx]      <= corr_hi_r;
      q_addr_lo[wr_idx] <= corr_addr_lo_r;
      q_addr_hi[wr_idx] <= corr_addr_hi_r;
      q_data_lo[wr_idx] <= sec_data_lo_r;
      q_data_hi[wr_idx] <= sec_data_hi_r;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!q_empty) state_next = q_lo[rd_idx] ? WR_LO : WR_HI;
      WR_LO:   if (wr.scrub_wr_ready) state_next = q_hi[rd_idx] ? WR_HI : IDLE;
      WR_HI:   if (wr.scrub_wr_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Head entry stays put until its pop, so the request is stable while waiting for ready.
  always_comb begin
    wr.scrub_wr_valid = 1'b0;
    wr.scrub_wr_addr  = '0;
    wr.scrub_wr_data  = '0;
    case (state_reg)
      WR_LO: begin
        wr.scrub_wr_valid = 1'b1;
        wr.scrub_wr_addr  = q_addr_lo[rd_idx];
        wr.scrub_wr_data  = q_data_lo[rd_idx];
      end
      WR_HI: begin
        wr.scrub_wr_valid = 1'b1;
        wr.scrub_wr_addr  = q_addr_hi[rd_idx];
        wr.scrub_wr_data  = q_data_hi[rd_idx];
      end
      default: ;
    endcase
  end

  assign wr.scrub_wr_ecc = ecc_encode(wr.scrub_wr_data);
  assign scrub_busy      = ~q_empty | (state_reg != IDLE);

  assign cnt_plus = cnt_reg + CNT_WIDTH'(1);

  // Dropped captures still count; clear beats a same-cycle increment.
  always_comb begin
    cnt_next  = cnt_reg;
    intr_next = 1'b0;
    if (corr_count_clr) begin
      cnt_next = '0;
    end else if (capture && !(&cnt_reg)) begin
      cnt_next  = cnt_plus;
      intr_next = (corr_thresh != '0) && (cnt_plus == corr_thresh);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt_reg  <= '0;
      intr_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      intr_reg <= intr_next;
      if (corr_count_clr) ovf_reg <= 1'b0;
      else if (drop)      ovf_reg <= 1'b1;
    end
  end

  assign corr_count       = cnt_reg;
  assign corr_thresh_intr = intr_reg;
  assign scrub_overflow   = ovf_reg;

endmodule
